// File: rtl/tuner_lock_ctrl.sv
// Sequences a tuner_search_phy sweep, picks a peak by policy and publishes its tune code; re-searches periodically.
// Trigger/peaks use val/rdy handshakes; a disable seen in WAIT still drains the pending peak list before idling.
module tuner_lock_ctrl #(
  parameter int DAC_WIDTH   = 8,
  parameter int ADC_WIDTH   = 8,
  parameter int NUM_TARGET  = 4,
  parameter int TIMER_WIDTH = 16,
  parameter int MAX_RETRY   = 3
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_cfg_en,
  input  logic                                  i_cfg_mode,
  input  logic [$clog2(NUM_TARGET)-1:0]         i_cfg_target_idx,
  input  logic [TIMER_WIDTH-1:0]                i_cfg_retune_period,
  output logic                                  o_search_trig_val,
  input  logic                                  i_search_trig_rdy,
  input  logic                                  i_search_peaks_val,
  output logic                                  o_search_peaks_rdy,
  input  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0]  i_ring_tune_peaks,
  input  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0]  i_pwr_detected_peaks,
  input  logic [$clog2(NUM_TARGET)-1:0]         i_ring_tune_peaks_cnt,
  output logic                                  o_lock_val,
  output logic [DAC_WIDTH-1:0]                  o_lock_tune,
  output logic [ADC_WIDTH-1:0]                  o_lock_pwr,
  output logic                                  o_lock_fail,
  output logic [$clog2(MAX_RETRY+1)-1:0]        o_retry_cnt,
  output logic [2:0]                            o_state
);
  localparam int IDX_W = $clog2(NUM_TARGET);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_TRIG = 3'd1, S_WAIT = 3'd2, S_SELECT = 3'd3, S_LOCKED = 3'd4, S_FAIL = 3'd5
  } state_t;

  state_t                               state_q, state_d;
  logic                                 lock_val_q, lock_val_d;
  logic [DAC_WIDTH-1:0]                 lock_tune_q, lock_tune_d;
  logic [ADC_WIDTH-1:0]                 lock_pwr_q, lock_pwr_d;
  logic                                 lock_fail_q, lock_fail_d;
  logic [RTY_W-1:0]                     retry_q, retry_d;
  logic [TIMER_WIDTH-1:0]               timer_q, timer_d;
  logic                                 dis_q, dis_d;
  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] tune_q, tune_d;
  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] pwr_q, pwr_d;
  logic [IDX_W-1:0]                     cnt_q, cnt_d;

  logic                                 sel_ok;
  logic [IDX_W-1:0]                     sel_idx;
  logic [ADC_WIDTH-1:0]                 best_pwr;
  logic [RTY_W-1:0]                     retry_inc;

  // Strict '>' keeps the lowest index on equal power.
  always_comb begin
    sel_ok   = 1'b0;
    sel_idx  = '0;
    best_pwr = '0;
    if (!i_cfg_mode) begin
      for (int i = 0; i < NUM_TARGET; i++) begin
        if (i < int'(cnt_q) && (!sel_ok || pwr_q[i] > best_pwr)) begin
          sel_ok   = 1'b1;
          sel_idx  = IDX_W'(i);
          best_pwr = pwr_q[i];
        end
      end
    end else begin
      sel_ok  = (i_cfg_target_idx < cnt_q);
      sel_idx = i_cfg_target_idx;
    end
  end

  assign retry_inc = (retry_q == RTY_W'(MAX_RETRY)) ? retry_q : retry_q + RTY_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      lock_val_q  <= 1'b0;
      lock_tune_q <= '0;
      lock_pwr_q  <= '0;
      lock_fail_q <= 1'b0;
      retry_q     <= '0;
      timer_q     <= '0;
      dis_q       <= 1'b0;
      tune_q      <= '0;
      pwr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      lock_val_q  <= lock_val_d;
      lock_tune_q <= lock_tune_d;
      lock_pwr_q  <= lock_pwr_d;
      lock_fail_q <= lock_fail_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      dis_q       <= dis_d;
      tune_q      <= tune_d;
      pwr_q       <= pwr_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_cfg_en) state_d = S_TRIG;
      S_TRIG: begin
        if (i_search_trig_rdy) state_d = S_WAIT;
        else if (!i_cfg_en)    state_d = S_IDLE;
      end
      S_WAIT:   if (i_search_peaks_val) state_d = (dis_q || !i_cfg_en) ? S_IDLE : S_SELECT;
      S_SELECT: begin
        if (!i_cfg_en)                         state_d = S_IDLE;
        else if (sel_ok)                       state_d = S_LOCKED;
        else if (retry_inc == RTY_W'(MAX_RETRY)) state_d = S_FAIL;
        else                                   state_d = S_TRIG;
      end
      S_LOCKED: begin
        if (!i_cfg_en)                         state_d = S_IDLE;
        else if (timer_q == TIMER_WIDTH'(1))   state_d = S_TRIG;
      end
      S_FAIL:   if (!i_cfg_en) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lock_val_d  = lock_val_q;
    lock_tune_d = lock_tune_q;
    lock_pwr_d  = lock_pwr_q;
    lock_fail_d = lock_fail_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    dis_d       = 1'b0;
    tune_d      = tune_q;
    pwr_d       = pwr_q;
    cnt_d       = cnt_q;

    // A disable arriving with (or after) an accepted trigger is remembered until the peak list drains.
    if (state_q == S_TRIG && i_search_trig_rdy) dis_d = !i_cfg_en;
    if (state_q == S_WAIT && !i_search_peaks_val) dis_d = dis_q || !i_cfg_en;

    if (state_q == S_IDLE && state_d == S_TRIG) begin
      lock_fail_d = 1'b0;
      retry_d     = '0;
    end
    if (state_q == S_WAIT && state_d == S_SELECT) begin
      tune_d = i_ring_tune_peaks;
      pwr_d  = i_pwr_detected_peaks;
      cnt_d  = i_ring_tune_peaks_cnt;
    end
    if (state_q == S_SELECT && i_cfg_en) begin
      if (sel_ok) begin
        lock_tune_d = tune_q[sel_idx];
        lock_pwr_d  = pwr_q[sel_idx];
        lock_val_d  = 1'b1;
        retry_d     = '0;
        timer_d     = i_cfg_retune_period;
      end else begin
        retry_d = retry_inc;
      end
    end
    if (state_q == S_LOCKED && timer_q != '0) timer_d = timer_q - TIMER_WIDTH'(1);
    if (state_d == S_FAIL) lock_fail_d = 1'b1;
    if (state_d == S_IDLE || state_d == S_FAIL) lock_val_d = 1'b0;
  end

  always_comb begin
    o_search_trig_val  = (state_q == S_TRIG);
    o_search_peaks_rdy = (state_q == S_WAIT);
    o_lock_val         = lock_val_q;
    o_lock_tune        = lock_tune_q;
    o_lock_pwr         = lock_pwr_q;
    o_lock_fail        = lock_fail_q;
    o_retry_cnt        = retry_q;
    o_state            = state_q;
  end
endmodule

// File: tb/tb_tuner_lock_ctrl.sv
// Bench for tuner_lock_ctrl: vector table, hand-written corner sequences, then random searches vs a reference model.
module tb_tuner_lock_ctrl;
  localparam int NT = 4;
  localparam int MR = 3;
  typedef logic [NT-1:0][7:0] pk_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic [1:0]  tidx = 2'd0;
  logic [15:0] period = 16'd0;
  logic        trig_rdy = 1'b0;
  logic        peaks_val = 1'b0;
  pk_t         tune_in = '0;
  pk_t         pwr_in = '0;
  logic [1:0]  cnt_in = 2'd0;

  logic        trig_val, peaks_rdy, lock_val, lock_fail;
  logic [7:0]  lock_tune, lock_pwr;
  logic [1:0]  retry_cnt;
  logic [2:0]  state;

  int n_pass = 0;
  int n_tot  = 0;

  tuner_lock_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_en(en), .i_cfg_mode(mode),
    .i_cfg_target_idx(tidx), .i_cfg_retune_period(period),
    .o_search_trig_val(trig_val), .i_search_trig_rdy(trig_rdy),
    .i_search_peaks_val(peaks_val), .o_search_peaks_rdy(peaks_rdy),
    .i_ring_tune_peaks(tune_in), .i_pwr_detected_peaks(pwr_in),
    .i_ring_tune_peaks_cnt(cnt_in),
    .o_lock_val(lock_val), .o_lock_tune(lock_tune), .o_lock_pwr(lock_pwr),
    .o_lock_fail(lock_fail), .o_retry_cnt(retry_cnt), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic pk_t pk(input int a0, input int a1, input int a2, input int a3);
    pk_t r;
    r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
    return r;
  endfunction

  // which: 0 = trigger valid, 1 = peaks ready; bounded wait on negedges
  task automatic wait_for(input int which);
    int b = 0;
    while (((which == 0) ? trig_val : peaks_rdy) == 1'b0 && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk((which == 0) ? "wait_trig" : "wait_peaks", int'((which == 0) ? trig_val : peaks_rdy), 1);
  endtask

  // Acts as the phy for one full search; returns two negedges after the peak handshake.
  task automatic serve(input pk_t t, input pk_t p, input logic [1:0] c);
    wait_for(0);
    trig_rdy = 1'b1;
    @(negedge clk);
    trig_rdy = 1'b0;
    wait_for(1);
    peaks_val = 1'b1; tune_in = t; pwr_in = p; cnt_in = c;
    @(negedge clk);
    peaks_val = 1'b0;
    @(negedge clk);
  endtask

  // Reference pick: max power among the first c entries, then the first index holding it.
  function automatic void model(input logic m, input logic [1:0] ix, input logic [1:0] c,
                                input pk_t p, output bit ok, output int sel);
    int mx;
    ok = 1'b0; sel = 0; mx = -1;
    if (m) begin
      ok  = (ix < c);
      sel = int'(ix);
    end else begin
      for (int i = 0; i < int'(c); i++) if (int'(p[i]) > mx) mx = int'(p[i]);
      for (int i = int'(c) - 1; i >= 0; i--) if (int'(p[i]) == mx) sel = i;
      ok = (c != 2'd0);
    end
  endfunction

  typedef struct {
    logic       mode;
    logic [1:0] idx;
    logic [1:0] cnt;
    pk_t        tune;
    pk_t        pwr;
    int         exp_state;
    int         exp_tune;
    int         exp_pwr;
  } vec_t;

  vec_t vt[7];

  initial begin
    bit ok;
    int sel, exp_st, m_retry, m_val, m_tune, m_pwr;
    pk_t rt, rp;
    logic [1:0] rc;

    vt[0] = '{1'b0, 2'd0, 2'd3, pk(10, 40, 90, 0),  pk(50, 200, 120, 0), 4, 40, 200};
    vt[1] = '{1'b0, 2'd0, 2'd3, pk(11, 22, 33, 44), pk(100, 100, 30, 0), 4, 11, 100};
    vt[2] = '{1'b0, 2'd0, 2'd0, pk(1, 2, 3, 4),     pk(9, 9, 9, 9),      1, 0, 0};
    vt[3] = '{1'b1, 2'd2, 2'd2, pk(1, 2, 3, 4),     pk(9, 9, 9, 9),      1, 0, 0};
    vt[4] = '{1'b1, 2'd1, 2'd2, pk(5, 6, 7, 8),     pk(7, 8, 9, 10),     4, 6, 8};
    vt[5] = '{1'b0, 2'd0, 2'd1, pk(77, 1, 2, 3),    pk(10, 250, 0, 255), 4, 77, 10};
    vt[6] = '{1'b1, 2'd0, 2'd3, pk(99, 1, 2, 3),    pk(3, 200, 200, 0),  4, 99, 3};

    repeat (3) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_trig_val", int'(trig_val), 0);
    chk("rst_lock_val", int'(lock_val), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_hold", int'(state), 0);

    for (int v = 0; v < 7; v++) begin
      mode = vt[v].mode; tidx = vt[v].idx; en = 1'b1;
      serve(vt[v].tune, vt[v].pwr, vt[v].cnt);
      chk($sformatf("vec%0d_state", v), int'(state), vt[v].exp_state);
      if (vt[v].exp_state == 4) begin
        chk($sformatf("vec%0d_tune", v), int'(lock_tune), vt[v].exp_tune);
        chk($sformatf("vec%0d_pwr", v), int'(lock_pwr), vt[v].exp_pwr);
        chk($sformatf("vec%0d_val", v), int'(lock_val), 1);
      end else begin
        chk($sformatf("vec%0d_retry", v), int'(retry_cnt), 1);
      end
      en = 1'b0;
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d_idle", v), int'(state), 0);
    end

    // Periodic retune, then retries exhausted from LOCKED
    en = 1'b1; mode = 1'b0; period = 16'd20;
    serve(pk(10, 40, 90, 0), pk(50, 200, 120, 0), 2'd3);
    chk("rt_locked", int'(state), 4);
    repeat (19) @(negedge clk);
    chk("rt_early", int'(trig_val), 0);
    @(negedge clk);
    chk("rt_at_20", int'(trig_val), 1);
    chk("rt_tune_held", int'(lock_tune), 40);
    chk("rt_val_held", int'(lock_val), 1);
    serve(pk(70, 0, 0, 0), pk(5, 0, 0, 0), 2'd1);
    chk("rt_new_tune", int'(lock_tune), 70);
    chk("rt_new_pwr", int'(lock_pwr), 5);
    mode = 1'b1; tidx = 2'd2;
    for (int k = 1; k <= MR; k++) begin
      serve(pk(1, 2, 3, 4), pk(9, 9, 9, 9), 2'd2);
      chk($sformatf("rty%0d_cnt", k), int'(retry_cnt), k);
      if (k < MR) begin
        chk($sformatf("rty%0d_state", k), int'(state), 1);
        chk($sformatf("rty%0d_tune", k), int'(lock_tune), 70);
        chk($sformatf("rty%0d_val", k), int'(lock_val), 1);
      end
    end
    chk("fail_state", int'(state), 5);
    chk("fail_flag", int'(lock_fail), 1);
    chk("fail_val", int'(lock_val), 0);
    en = 1'b0;
    @(negedge clk);
    chk("fail_to_idle", int'(state), 0);
    chk("fail_sticky", int'(lock_fail), 1);
    en = 1'b1;
    @(negedge clk);
    chk("retrig_state", int'(state), 1);
    chk("retrig_fail_clr", int'(lock_fail), 0);

    // Disable during WAIT with a late peak list
    mode = 1'b0; period = 16'd5;
    serve(pk(33, 0, 0, 0), pk(8, 0, 0, 0), 2'd1);
    chk("dw_locked", int'(lock_tune), 33);
    wait_for(0);
    trig_rdy = 1'b1;
    @(negedge clk);
    trig_rdy = 1'b0; en = 1'b0;
    repeat (5) @(negedge clk);
    chk("dw_state", int'(state), 2);
    chk("dw_rdy", int'(peaks_rdy), 1);
    chk("dw_val_held", int'(lock_val), 1);
    peaks_val = 1'b1; tune_in = pk(200, 0, 0, 0); pwr_in = pk(250, 0, 0, 0); cnt_in = 2'd1;
    @(negedge clk);
    peaks_val = 1'b0;
    chk("dw_idle", int'(state), 0);
    chk("dw_val", int'(lock_val), 0);
    chk("dw_discard", int'(lock_tune), 33);

    // Reset while a trigger is pending
    en = 1'b1;
    serve(pk(21, 0, 0, 0), pk(4, 0, 0, 0), 2'd1);
    wait_for(0);
    rst = 1'b1;
    @(negedge clk);
    chk("rr_state", int'(state), 0);
    chk("rr_trig", int'(trig_val), 0);
    chk("rr_rdy", int'(peaks_rdy), 0);
    chk("rr_val", int'(lock_val), 0);
    chk("rr_tune", int'(lock_tune), 0);
    chk("rr_pwr", int'(lock_pwr), 0);
    chk("rr_fail", int'(lock_fail), 0);
    chk("rr_retry", int'(retry_cnt), 0);
    rst = 1'b0;

    // Random searches against the reference model
    period = 16'd3;
    m_retry = 0; m_val = 0; m_tune = 0; m_pwr = 0;
    for (int it = 0; it < 60; it++) begin
      mode = 1'($urandom_range(0, 1));
      tidx = 2'($urandom_range(0, 3));
      rc   = 2'($urandom_range(0, 3));
      for (int i = 0; i < NT; i++) begin
        rt[i] = 8'($urandom_range(0, 255));
        rp[i] = 8'($urandom_range(0, 3) * 60);
      end
      serve(rt, rp, rc);
      model(mode, tidx, rc, rp, ok, sel);
      if (ok) begin
        m_tune = int'(rt[sel]); m_pwr = int'(rp[sel]); m_val = 1; m_retry = 0; exp_st = 4;
      end else begin
        m_retry++;
        if (m_retry >= MR) begin exp_st = 5; m_val = 0; end
        else exp_st = 1;
      end
      chk($sformatf("rnd%0d_state", it), int'(state), exp_st);
      chk($sformatf("rnd%0d_val", it), int'(lock_val), m_val);
      chk($sformatf("rnd%0d_tune", it), int'(lock_tune), m_tune);
      chk($sformatf("rnd%0d_pwr", it), int'(lock_pwr), m_pwr);
      chk($sformatf("rnd%0d_retry", it), int'(retry_cnt), m_retry);
      if (exp_st == 5) begin
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        m_retry = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
